// File: rtl/line_draw_arbiter.sv
// Round-robin arbiter sharing one line-rasterizer engine between NUM_REQ line sequencers.
// Latches the granted line, launches the engine and acknowledges with a level ready.
module line_draw_arbiter #(
  parameter int NUM_REQ             = 2,
  parameter int COLOR_CHANNEL_DEPTH = 2,
  parameter int SKIP_HIDDEN         = 1,
  localparam int CW                 = 3 * COLOR_CHANNEL_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    request,
  output logic [NUM_REQ-1:0]    ready,
  input  logic [10*NUM_REQ-1:0] x0_in,
  input  logic [10*NUM_REQ-1:0] y0_in,
  input  logic [10*NUM_REQ-1:0] x1_in,
  input  logic [10*NUM_REQ-1:0] y1_in,
  input  logic [CW*NUM_REQ-1:0] color_in,
  input  logic [NUM_REQ-1:0]    dontShow_in,
  output logic [9:0]            x0_out,
  output logic [9:0]            y0_out,
  output logic [9:0]            x1_out,
  output logic [9:0]            y1_out,
  output logic [CW-1:0]         color_out,
  output logic                  line_start,
  input  logic                  line_done,
  output logic [1:0]            grant_id,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  // Handshake: a requester holds request[i] high with stable line data until it
  // sees ready[i] high, then drops request[i]; ready[i] falls the following cycle
  // and the requester must see it low before requesting again.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [NUM_REQ-1:0]   gnt_oh_q, gnt_oh_d;
  logic [1:0]           grant_q, grant_d;
  logic [1:0]           last_q, last_d;
  logic [9:0]           x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [CW-1:0]        color_q, color_d;

  logic                 found;
  logic [1:0]           pick;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [NUM_REQ-1:0]   eligible;
  logic [9:0]           x0_sel, y0_sel, x1_sel, y1_sel;
  logic [CW-1:0]        color_sel;
  logic                 hidden_sel;
  logic                 req_granted;

  assign eligible = request & ~ready_q;

  // Search last+1, last+2, ... modulo NUM_REQ; constant inner index keeps selects static.
  always_comb begin
    found   = 1'b0;
    pick    = 2'd0;
    pick_oh = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && eligible[i] && (((int'(last_q) + off) % NUM_REQ) == i)) begin
          found      = 1'b1;
          pick       = 2'(i);
          pick_oh[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    x0_sel    = '0;
    y0_sel    = '0;
    x1_sel    = '0;
    y1_sel    = '0;
    color_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        x0_sel    = x0_in[10*i +: 10];
        y0_sel    = y0_in[10*i +: 10];
        x1_sel    = x1_in[10*i +: 10];
        y1_sel    = y1_in[10*i +: 10];
        color_sel = color_in[CW*i +: CW];
      end
    end
  end

  assign hidden_sel  = (SKIP_HIDDEN != 0) && (|(dontShow_in & pick_oh));
  assign req_granted = |(request & gnt_oh_q);

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    gnt_oh_d = gnt_oh_q;
    grant_d  = grant_q;
    last_d   = last_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    color_d  = color_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          x0_d     = x0_sel;
          y0_d     = y0_sel;
          x1_d     = x1_sel;
          y1_d     = y1_sel;
          color_d  = color_sel;
          grant_d  = pick;
          gnt_oh_d = pick_oh;
          if (hidden_sel) begin
            ready_d = pick_oh;
            state_d = S_ACK;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (line_done) begin
          ready_d = gnt_oh_q;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!req_granted) begin
          ready_d = '0;
          last_d  = grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ready_q  <= '0;
      gnt_oh_q <= '0;
      grant_q  <= 2'd0;
      last_q   <= 2'(NUM_REQ - 1);
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      color_q  <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      gnt_oh_q <= gnt_oh_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      color_q  <= color_d;
    end
  end

  assign ready      = ready_q;
  assign x0_out     = x0_q;
  assign y0_out     = y0_q;
  assign x1_out     = x1_q;
  assign y1_out     = y1_q;
  assign color_out  = color_q;
  assign grant_id   = grant_q;
  assign line_start = (state_q == S_LAUNCH);
  assign busy       = (state_q != S_IDLE);
  assign state_dbg  = state_q;

endmodule
